// File: rtl/ifetch.sv
// ifetch: instruction fetch sequencer between the PC register and imem.
// Macro IFETCH_ALIGN_CHK_EN turns a misaligned pc_in into a fetch error.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   pc_in / pc_write       current PC in, PC advance enable out (comb)
//   flush                  drop buffered or in-flight fetch
//   imem_req/addr/ack/rdata  held request/acknowledge read port
//   inst_valid/ready       valid/ready handshake towards decode
//   inst, inst_pc          fetched word and its address
//   fetch_err, err_cause   sticky error, 01 timeout / 10 misaligned
//
// Parameter TIMEOUT (1..65535): REQ/DROP cycles without ack before error.

module ifetch #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic        pc_write,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_err,
    output logic [1:0]  err_cause
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DROP,
        S_ERR
    } state_t;

    localparam logic [15:0] TO_LIM    = 16'(TIMEOUT);
    localparam logic [1:0]  CAUSE_TO  = 2'b01;
    localparam logic [1:0]  CAUSE_MIS = 2'b10;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] ipc_q, ipc_d;
    logic        vld_q, vld_d;
    logic        err_q, err_d;
    logic [1:0]  cause_q, cause_d;
    logic [15:0] cnt_q, cnt_d;

    logic        misalign;
    logic        launch;
    logic [15:0] cnt_inc;
    logic        to_hit;

`ifdef IFETCH_ALIGN_CHK_EN
    assign misalign = |pc_in[1:0];
`else
    // Low PC bits are simply dropped from the request address.
    logic unused_pc_lo;
    assign unused_pc_lo = ^pc_in[1:0];
    assign misalign     = 1'b0;
`endif

    assign cnt_inc = cnt_q + 16'd1;
    assign to_hit  = (cnt_inc == TO_LIM);

    // Next-state and next-register values; outputs are all registered
    // except pc_write, which must coincide with the capture edge.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        addr_d   = addr_q;
        inst_d   = inst_q;
        ipc_d    = ipc_q;
        vld_d    = vld_q;
        err_d    = err_q;
        cause_d  = cause_q;
        cnt_d    = cnt_q;
        launch   = 1'b0;
        pc_write = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                launch = !flush;
            end

            S_REQ: begin
                if (flush) begin
                    if (imem_ack) begin
                        req_d   = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        // Request cannot be withdrawn; wait it out.
                        cnt_d   = '0;
                        state_d = S_DROP;
                    end
                end else if (imem_ack) begin
                    inst_d   = imem_rdata;
                    ipc_d    = addr_q;
                    vld_d    = 1'b1;
                    req_d    = 1'b0;
                    pc_write = 1'b1;
                    state_d  = S_HOLD;
                end else if (to_hit) begin
                    cnt_d   = cnt_inc;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    cause_d = CAUSE_TO;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_HOLD: begin
                if (flush) begin
                    vld_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (inst_ready) begin
                    vld_d  = 1'b0;
                    launch = 1'b1;
                end
            end

            S_DROP: begin
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (to_hit) begin
                    cnt_d   = cnt_inc;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    cause_d = CAUSE_TO;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_ERR: begin
                if (flush) begin
                    err_d   = 1'b0;
                    cause_d = 2'b00;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Shared launch path for IDLE and HOLD acceptance.
        if (launch) begin
            if (misalign) begin
                err_d   = 1'b1;
                cause_d = CAUSE_MIS;
                state_d = S_ERR;
            end else begin
                addr_d  = {pc_in[31:2], 2'b00};
                req_d   = 1'b1;
                cnt_d   = '0;
                state_d = S_REQ;
            end
        end

        if (rst) begin
            pc_write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            inst_q  <= '0;
            ipc_q   <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            cause_q <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            ipc_q   <= ipc_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign inst       = inst_q;
    assign inst_pc    = ipc_q;
    assign inst_valid = vld_q;
    assign fetch_err  = err_q;
    assign err_cause  = cause_q;

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed bench for ifetch with TIMEOUT=4.
// Cycle-by-cycle stimulus with hand-computed expectations.

module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_write;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_err;
    logic [1:0]  err_cause;

    int n_chk  = 0;
    int n_fail = 0;

    ifetch #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .pc_write   (pc_write),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .fetch_err  (fetch_err),
        .err_cause  (err_cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; registered outputs settle by #1.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs follow freshly driven inputs.
    task automatic settle;
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        pc_in      = 32'h0;
        flush      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        inst_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_ipc", inst_pc, 32'h0);
        check("rst_vld", 32'(inst_valid), 32'h0);
        check("rst_err", 32'(fetch_err), 32'h0);
        check("rst_cause", 32'(err_cause), 32'h0);
        check("rst_pcw", 32'(pc_write), 32'h0);

        // Zero-wait fetch
        rst = 1'b0;
        tick();
        check("zw_req0", 32'(imem_req), 32'h1);
        check("zw_addr0", imem_addr, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0013;
        inst_ready = 1'b1;
        settle();
        check("zw_pcw0", 32'(pc_write), 32'h1);
        tick();
        imem_ack = 1'b0;
        pc_in    = 32'h4;
        settle();
        check("zw_vld0", 32'(inst_valid), 32'h1);
        check("zw_inst0", inst, 32'h0000_0013);
        check("zw_ipc0", inst_pc, 32'h0);
        check("zw_reqlo", 32'(imem_req), 32'h0);
        check("zw_pcwlo", 32'(pc_write), 32'h0);
        tick();
        check("zw_req1", 32'(imem_req), 32'h1);
        check("zw_addr1", imem_addr, 32'h4);
        check("zw_vldlo", 32'(inst_valid), 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0010_0093;
        settle();
        check("zw_pcw1", 32'(pc_write), 32'h1);
        tick();
        check("zw_inst1", inst, 32'h0010_0093);
        check("zw_ipc1", inst_pc, 32'h4);

        // Backpressure for 5 cycles, accept on the 6th
        imem_ack   = 1'b0;
        inst_ready = 1'b0;
        pc_in      = 32'h8;
        settle();
        for (int i = 0; i < 5; i++) begin
            check("bp_vld", 32'(inst_valid), 32'h1);
            check("bp_inst", inst, 32'h0010_0093);
            check("bp_ipc", inst_pc, 32'h4);
            check("bp_req", 32'(imem_req), 32'h0);
            check("bp_pcw", 32'(pc_write), 32'h0);
            tick();
        end
        inst_ready = 1'b1;
        settle();
        check("bp_vld6", 32'(inst_valid), 32'h1);
        tick();
        check("bp_req6", 32'(imem_req), 32'h1);
        check("bp_addr6", imem_addr, 32'h8);
        check("bp_vldlo", 32'(inst_valid), 32'h0);

        // Flush in flight: REQ cycle 2, ack in cycle 4
        tick();
        flush = 1'b1;
        settle();
        check("fl_req2", 32'(imem_req), 32'h1);
        check("fl_pcw2", 32'(pc_write), 32'h0);
        tick();
        flush = 1'b0;
        settle();
        check("fl_req3", 32'(imem_req), 32'h1);
        check("fl_vld3", 32'(inst_valid), 32'h0);
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        pc_in      = 32'h100;
        settle();
        check("fl_req4", 32'(imem_req), 32'h1);
        check("fl_pcw4", 32'(pc_write), 32'h0);
        tick();
        imem_ack = 1'b0;
        settle();
        check("fl_idle_req", 32'(imem_req), 32'h0);
        check("fl_idle_vld", 32'(inst_valid), 32'h0);
        tick();
        check("fl_new_req", 32'(imem_req), 32'h1);
        check("fl_new_addr", imem_addr, 32'h100);

        // Ack and flush in the same cycle
        imem_ack   = 1'b1;
        imem_rdata = 32'h5555_5555;
        flush      = 1'b1;
        settle();
        check("af_pcw", 32'(pc_write), 32'h0);
        tick();
        imem_ack = 1'b0;
        flush    = 1'b0;
        pc_in    = 32'h200;
        settle();
        check("af_req", 32'(imem_req), 32'h0);
        check("af_vld", 32'(inst_valid), 32'h0);
        tick();
        check("af_new_req", 32'(imem_req), 32'h1);
        check("af_new_addr", imem_addr, 32'h200);

        // Timeout: error 4 edges after REQ entry
        for (int i = 1; i < 4; i++) begin
            tick();
            check("to_err_lo", 32'(fetch_err), 32'h0);
            check("to_req_hi", 32'(imem_req), 32'h1);
        end
        tick();
        check("to_err", 32'(fetch_err), 32'h1);
        check("to_cause", 32'(err_cause), 32'h1);
        check("to_req", 32'(imem_req), 32'h0);
        imem_ack = 1'b1;
        settle();
        check("to_pcw", 32'(pc_write), 32'h0);
        tick();
        imem_ack = 1'b0;
        check("to_sticky", 32'(fetch_err), 32'h1);
        check("to_sticky_req", 32'(imem_req), 32'h0);
        check("to_sticky_vld", 32'(inst_valid), 32'h0);
        flush = 1'b1;
        tick();
        check("to_clr_err", 32'(fetch_err), 32'h0);
        check("to_clr_cause", 32'(err_cause), 32'h0);
        tick();
        check("to_idle_req", 32'(imem_req), 32'h0);
        flush = 1'b0;

        // Misaligned PC
        pc_in = 32'h6;
        tick();
`ifdef IFETCH_ALIGN_CHK_EN
        check("mis_req", 32'(imem_req), 32'h0);
        check("mis_err", 32'(fetch_err), 32'h1);
        check("mis_cause", 32'(err_cause), 32'h2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("mis_clr", 32'(fetch_err), 32'h0);
`else
        check("mis_req", 32'(imem_req), 32'h1);
        check("mis_addr", imem_addr, 32'h4);
        check("mis_err", 32'(fetch_err), 32'h0);
`endif

        // Reset mid-operation, pending ack must be ignored
        pc_in    = 32'h8;
        rst      = 1'b1;
        imem_ack = 1'b1;
        settle();
        check("mr_pcw", 32'(pc_write), 32'h0);
        tick();
        check("mr_req", 32'(imem_req), 32'h0);
        check("mr_addr", imem_addr, 32'h0);
        check("mr_inst", inst, 32'h0);
        check("mr_ipc", inst_pc, 32'h0);
        check("mr_err", 32'(fetch_err), 32'h0);
        rst = 1'b0;
        settle();
        check("mr_idle_pcw", 32'(pc_write), 32'h0);
        tick();
        imem_ack = 1'b0;
        check("mr_relaunch", 32'(imem_req), 32'h1);
        check("mr_reladdr", imem_addr, 32'h8);
        check("mr_vld", 32'(inst_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
